// File: rtl/sum_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module   : sum_normalize_pack
// Brief    : FP adder return path. Renormalizes the raw 25-bit mantissa
//            sum/difference one step per cycle, adjusts the exponent,
//            resolves zero/overflow/underflow and packs a Float32 result.
// Revision : 1.0 - initial release
// ============================================================================
module sum_normalize_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow
);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_NORM = 2'd1,
        c_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_EXP_MAX = 8'd255;  // infinity / NaN exponent
    localparam logic [7:0] c_EXP_SAT = 8'd254;  // largest finite exponent

    state_t      r_state;
    logic        r_sign;
    logic [7:0]  r_exp;
    logic [24:0] r_sum;
    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic        r_out_overflow;
    logic        r_out_underflow;

    // Outcome of one normalization step on the latched operand
    logic        w_finish;
    logic [31:0] w_result;
    logic        w_overflow;
    logic        w_underflow;

    assign in_ready      = rst_n && (r_state == c_IDLE);
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_overflow  = r_out_overflow;
    assign out_underflow = r_out_underflow;

    // Priority-ordered termination rules; falling through all of them means
    // one more left shift is needed.
    always_comb begin
        w_finish    = 1'b1;
        w_result    = 32'd0;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        if (r_sum == 25'd0) begin
            // Exact cancellation always yields +0
            w_result = 32'd0;
        end else if (r_exp == c_EXP_MAX) begin
            w_result   = {r_sign, c_EXP_MAX, 23'd0};
            w_overflow = 1'b1;
        end else if (r_sum[24]) begin
            // Carry out: one right shift, dropped LSB is truncated
            if (r_exp == c_EXP_SAT) begin
                w_result   = {r_sign, c_EXP_MAX, 23'd0};
                w_overflow = 1'b1;
            end else begin
                w_result = {r_sign, r_exp + 8'd1, r_sum[23:1]};
            end
        end else if (r_exp == 8'd0) begin
            // Denormal range is flushed, keeping the sign
            w_result    = {r_sign, 31'd0};
            w_underflow = 1'b1;
        end else if (r_sum[23]) begin
            w_result = {r_sign, r_exp, r_sum[22:0]};
        end else begin
            w_finish = 1'b0;
        end
    end

    // Handshake FSM with operand latch, iterative shifter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_sign          <= 1'b0;
            r_exp           <= 8'd0;
            r_sum           <= 25'd0;
            r_out_valid     <= 1'b0;
            r_out_result    <= 32'd0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= in_sign;
                        r_exp   <= in_exp;
                        r_sum   <= in_sum;
                        r_state <= c_NORM;
                    end
                end
                c_NORM: begin
                    if (w_finish) begin
                        r_out_result    <= w_result;
                        r_out_overflow  <= w_overflow;
                        r_out_underflow <= w_underflow;
                        r_out_valid     <= 1'b1;
                        r_state         <= c_DONE;
                    end else begin
                        r_sum <= {r_sum[23:0], 1'b0};
                        r_exp <= r_exp - 8'd1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_normalize_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_normalize_pack
// Brief    : Self-checking bench for sum_normalize_pack with directed cases,
//            handshake scenarios and randomized operands against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [24:0] in_sum = 25'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    sum_normalize_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_sum       (in_sum),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: count leading zeros above the implicit-one position to get
    // the shift count, then decide whether the exponent survives it.
    function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] sm,
                                  output logic [31:0] res, output logic ov, output logic un,
                                  output int lat);
        int p;
        int k;
        logic [24:0] t;
        res = 32'd0; ov = 1'b0; un = 1'b0; lat = 2;
        if (sm == 25'd0) begin
            res = 32'd0;
        end else if (e == 8'd255) begin
            res = {s, 8'hFF, 23'd0}; ov = 1'b1;
        end else if (sm[24]) begin
            if (e == 8'd254) begin
                res = {s, 8'hFF, 23'd0}; ov = 1'b1;
            end else begin
                res = {s, e + 8'd1, sm[23:1]};
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (sm[i]) p = i;
            k = 23 - p;
            if (int'(e) <= k) begin
                res = {s, 31'd0}; un = 1'b1; lat = 2 + int'(e);
            end else begin
                t   = sm << k;
                res = {s, e - 8'(k), t[22:0]};
                lat = 2 + k;
            end
        end
    endfunction

    // Drive one operand and wait for its result. Entered and left at a negedge.
    // lat is the index of the first edge (accept edge = 0) at which out_valid
    // is seen high. With rdy=1 the result is consumed before returning.
    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] sm, input logic rdy,
                          output logic [31:0] res, output logic ov, output logic un,
                          output int lat, output logic leak, output logic to, output int acc);
        int w;
        res = 32'd0; ov = 1'b0; un = 1'b0; lat = 0; leak = 1'b0; to = 1'b0; acc = 0;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        if (!in_ready) begin to = 1'b1; return; end
        in_valid = 1'b1; in_sign = s; in_exp = e; in_sum = sm; out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        in_valid = $urandom_range(0, 1) == 1;
        in_sign  = 1'($urandom);
        in_exp   = 8'($urandom);
        in_sum   = 25'($urandom);
        for (int n = 1; n <= 100; n++) begin
            if (in_ready) leak = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                lat = n + 1;
                res = out_result; ov = out_overflow; un = out_underflow;
                break;
            end
        end
        if (lat == 0) begin to = 1'b1; return; end
        if (rdy) begin
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        n_cmp++;
        if ({out_result, out_overflow, out_underflow} !== 34'd0) begin
            n_err++; $display("FAIL reset_out: result=%h ov=%b un=%b want 0", out_result, out_overflow, out_underflow);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [24:0] sm;
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic [7:0]  lat;
    } dir_t;

    task automatic test_directed;
        dir_t tbl[9];
        logic [31:0] r; logic ov, un, lk, to; int lat, acc;
        tbl[0] = '{1'b0, 8'd127, 25'h1000000, 32'h40000000, 1'b0, 1'b0, 8'd2};
        tbl[1] = '{1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 1'b0, 1'b0, 8'd2};
        tbl[2] = '{1'b0, 8'd130, 25'h0000001, 32'h35800000, 1'b0, 1'b0, 8'd25};
        tbl[3] = '{1'b1, 8'd90,  25'h0000000, 32'h00000000, 1'b0, 1'b0, 8'd2};
        tbl[4] = '{1'b1, 8'd254, 25'h1800000, 32'hFF800000, 1'b1, 1'b0, 8'd2};
        tbl[5] = '{1'b0, 8'd3,   25'h0000100, 32'h00000000, 1'b0, 1'b1, 8'd5};
        tbl[6] = '{1'b0, 8'd255, 25'h0800000, 32'h7F800000, 1'b1, 1'b0, 8'd2};
        tbl[7] = '{1'b1, 8'd0,   25'h0800000, 32'h80000000, 1'b0, 1'b1, 8'd2};
        tbl[8] = '{1'b0, 8'd100, 25'h1FFFFFF, 32'h32FFFFFF, 1'b0, 1'b0, 8'd2};
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].s, tbl[i].e, tbl[i].sm, 1'b0, r, ov, un, lat, lk, to, acc);
            n_cmp++;
            if (to || r !== tbl[i].res || ov !== tbl[i].ov || un !== tbl[i].un) begin
                n_err++;
                $display("FAIL dir%0d_result: got %h ov=%b un=%b to=%b want %h ov=%b un=%b",
                         i, r, ov, un, to, tbl[i].res, tbl[i].ov, tbl[i].un);
            end
            n_cmp++;
            if (lat != int'(tbl[i].lat) || lk) begin
                n_err++;
                $display("FAIL dir%0d_latency: got edge %0d ready_leak=%b want edge %0d ready_leak=0",
                         i, lat, lk, tbl[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r; logic ov, un, lk, to; int lat, acc;
        run_op(1'b0, 8'd127, 25'h0A00000, 1'b0, r, ov, un, lat, lk, to, acc);
        n_cmp++;
        if (to || r !== 32'h3FA00000) begin
            n_err++; $display("FAIL bp_first: got %h to=%b want 3fa00000", r, to);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd200; in_sum = 25'h1FFFFFF;
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h3FA00000 ||
                out_overflow !== 1'b0 || out_underflow !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h ov=%b un=%b want 1 0 3fa00000 0 0",
                         i, out_valid, in_ready, out_result, out_overflow, out_underflow);
            end
        end
        in_valid = 1'b0;
        consume();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h3FA00000) begin
            n_err++;
            $display("FAIL bp_drain: valid=%b ready=%b result=%h want 0 1 3fa00000", out_valid, in_ready, out_result);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_ghost: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; logic ov, un, lk, to; int lat, acc;
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd130; in_sum = 25'h0000001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL rstmid_hold: valid=%b ready=%b want 0 0", out_valid, in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_result !== 32'd0) begin
            n_err++; $display("FAIL rstmid_idle: ready=%b result=%h want 1 00000000", in_ready, out_result);
        end
        repeat (30) begin
            @(negedge clk);
            if (out_valid) break;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_discard: valid=%b want 0", out_valid);
        end
        // Reset while a result is held in DONE
        run_op(1'b1, 8'd254, 25'h1800000, 1'b0, r, ov, un, lat, lk, to, acc);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (to || out_valid !== 1'b0 || out_result !== 32'd0 || out_overflow !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstdone: to=%b valid=%b result=%h ov=%b ready=%b want 0 0 00000000 0 1",
                     to, out_valid, out_result, out_overflow, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; logic ov, un, lk, to; int lat, acc, prev_acc, prev_lat;
        logic [31:0] er; logic eov, eun; int elat;
        logic [24:0] sums[3];
        sums[0] = 25'h0800000; sums[1] = 25'h0000400; sums[2] = 25'h1000001;
        prev_acc = 0; prev_lat = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 8'd120, sums[i], 1'b1, r, ov, un, lat, lk, to, acc);
            model(1'b0, 8'd120, sums[i], er, eov, eun, elat);
            n_cmp++;
            if (to || r !== er || lat != elat || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b%0d_op: got %h lat=%0d valid=%b ready=%b want %h lat=%0d valid=0 ready=1",
                         i, r, lat, out_valid, in_ready, er, elat);
            end
            if (i > 0) begin
                n_cmp++;
                if (acc - prev_acc != prev_lat + 1) begin
                    n_err++;
                    $display("FAIL b2b%0d_rate: got %0d cycles want %0d", i, acc - prev_acc, prev_lat + 1);
                end
            end
            prev_acc = acc; prev_lat = lat;
        end
    endtask

    task automatic test_random;
        logic [31:0] r; logic ov, un, lk, to; int lat, acc;
        logic [31:0] er; logic eov, eun; int elat;
        logic s; logic [7:0] e; logic [24:0] sm; logic rdy; int mode; int p;
        for (int it = 0; it < 60; it++) begin
            s    = 1'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) sm = 25'd0;
            else if (mode <= 2) sm = {1'b1, 24'($urandom)};
            else begin
                p  = $urandom_range(0, 23);
                sm = (25'd1 << p) | (25'($urandom) & ((25'd1 << p) - 25'd1));
            end
            mode = $urandom_range(0, 9);
            if (mode <= 2) e = 8'($urandom_range(0, 25));
            else if (mode == 3) e = 8'($urandom_range(253, 255));
            else e = 8'($urandom);
            rdy = 1'($urandom);
            model(s, e, sm, er, eov, eun, elat);
            run_op(s, e, sm, rdy, r, ov, un, lat, lk, to, acc);
            n_cmp++;
            if (to || r !== er || ov !== eov || un !== eun || lat != elat || lk) begin
                n_err++;
                $display("FAIL rand%0d: in s=%b e=%0d sum=%h got %h ov=%b un=%b lat=%0d leak=%b want %h ov=%b un=%b lat=%0d",
                         it, s, e, sm, r, ov, un, lat, lk, er, eov, eun, elat);
            end
            if (!rdy && !to) consume();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
